// File: rtl/hex_word_tx.sv
// Converts a parallel word into an uppercase ASCII hex character stream (MS nibble first),
// optionally terminated by CR LF, with valid/ready handshakes on both sides.
module hex_word_tx #(
    parameter int WIDTH       = 32,
    parameter bit APPEND_CRLF = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] word_in,
    input  logic             word_valid,
    output logic             word_ready,
    output logic [7:0]       tx_data,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic             busy
);

    localparam int DIGITS = WIDTH / 4;
    localparam int CW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CW-1:0] LAST_DIGIT = CW'(DIGITS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HEX,
        S_CRLF
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_shift;
    logic [CW-1:0]    r_count;
    logic             r_crlfSel;
    logic [7:0]       r_txData;
    logic             r_txValid;
    logic             r_wordReady;

    logic w_accept;
    logic w_fire;

    function automatic logic [7:0] toAscii(input logic [3:0] nibble);
        return (nibble < 4'd10) ? (8'h30 + {4'h0, nibble}) : (8'h37 + {4'h0, nibble});
    endfunction

    assign w_accept = word_valid && r_wordReady;
    assign w_fire   = r_txValid && tx_ready;

    // tx_data always holds the character on offer; the shift register holds the digits not yet loaded.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_shift     <= '0;
            r_count     <= '0;
            r_crlfSel   <= 1'b0;
            r_txData    <= 8'h00;
            r_txValid   <= 1'b0;
            r_wordReady <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_shift     <= word_in << 4;
                        r_txData    <= toAscii(word_in[WIDTH-1 -: 4]);
                        r_txValid   <= 1'b1;
                        r_wordReady <= 1'b0;
                        r_count     <= '0;
                        r_state     <= S_HEX;
                    end
                end
                S_HEX: begin
                    if (w_fire) begin
                        r_count <= r_count + 1'b1;
                        if (r_count == LAST_DIGIT) begin
                            if (APPEND_CRLF) begin
                                r_txData  <= 8'h0D;
                                r_crlfSel <= 1'b0;
                                r_state   <= S_CRLF;
                            end else begin
                                r_txValid   <= 1'b0;
                                r_wordReady <= 1'b1;
                                r_state     <= S_IDLE;
                            end
                        end else begin
                            r_txData <= toAscii(r_shift[WIDTH-1 -: 4]);
                            r_shift  <= r_shift << 4;
                        end
                    end
                end
                S_CRLF: begin
                    if (w_fire) begin
                        if (!r_crlfSel) begin
                            r_txData  <= 8'h0A;
                            r_crlfSel <= 1'b1;
                        end else begin
                            r_crlfSel   <= 1'b0;
                            r_txValid   <= 1'b0;
                            r_wordReady <= 1'b1;
                            r_state     <= S_IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign word_ready = r_wordReady;
    assign busy       = !r_wordReady;
    assign tx_data    = r_txData;
    assign tx_valid   = r_txValid;

endmodule

// File: tb/tb_hex_word_tx.sv
// Directed bench for hex_word_tx: a 32-bit CRLF instance driven from a vector table,
// plus hand-written sequences for reset mid-stream and an 8-bit instance without CRLF.
module tb_hex_word_tx;

    logic        clk = 1'b0;
    logic        reset;

    logic [31:0] wordIn;
    logic        wordValid;
    logic        wordReady;
    logic [7:0]  txData;
    logic        txValid;
    logic        txReady;
    logic        busy;

    logic [7:0]  wordIn8;
    logic        wordValid8;
    logic        wordReady8;
    logic [7:0]  txData8;
    logic        txValid8;
    logic        txReady8;
    logic        busy8;

    int nCompared   = 0;
    int nMismatched = 0;

    typedef struct {
        logic [31:0] word;
        int          period;
        int          dropAt;
        bit          holdNext;
        logic [31:0] nextWord;
        logic [79:0] expBytes;
    } vec_t;

    vec_t vecs[5];
    vec_t vecAfterReset;

    always #5 clk = ~clk;

    hex_word_tx #(.WIDTH(32), .APPEND_CRLF(1'b1)) dut32 (
        .clk        (clk),
        .reset      (reset),
        .word_in    (wordIn),
        .word_valid (wordValid),
        .word_ready (wordReady),
        .tx_data    (txData),
        .tx_valid   (txValid),
        .tx_ready   (txReady),
        .busy       (busy)
    );

    hex_word_tx #(.WIDTH(8), .APPEND_CRLF(1'b0)) dut8 (
        .clk        (clk),
        .reset      (reset),
        .word_in    (wordIn8),
        .word_valid (wordValid8),
        .word_ready (wordReady8),
        .tx_data    (txData8),
        .tx_valid   (txValid8),
        .tx_ready   (txReady8),
        .busy       (busy8)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nCompared++;
        if (actual !== expected) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // One word through the 32-bit instance; returns right after the negedge preceding the final handshake.
    task automatic applyStimulus(input vec_t v);
        int          idx;
        int          cyc;
        bit          stalled;
        bit          ready;
        logic [7:0]  prevData;
        logic [79:0] e;
        e        = v.expBytes;
        idx      = 0;
        stalled  = 1'b0;
        prevData = 8'h00;

        @(negedge clk);
        checkOutput("idleWordReady", {31'd0, wordReady}, 32'd1);
        checkOutput("idleTxValid", {31'd0, txValid}, 32'd0);
        wordValid = 1'b1;
        wordIn    = v.word;
        txReady   = 1'b0;

        @(negedge clk);
        wordValid = v.holdNext;
        wordIn    = v.holdNext ? v.nextWord : 32'hA5A5_5A5A;
        checkOutput("firstDigitLatency", {31'd0, txValid}, 32'd1);
        checkOutput("busyAfterAccept", {31'd0, busy}, 32'd1);

        for (cyc = 0; idx < 10 && cyc < 200; cyc++) begin
            if (cyc > 0) @(negedge clk);
            ready   = ((cyc % v.period) == (v.period - 1));
            txReady = ready;
            if (v.holdNext) begin
                wordValid = 1'b1;
                wordIn    = v.nextWord;
            end else if (cyc == v.dropAt) begin
                wordValid = 1'b1;
                wordIn    = 32'h1234_5678;
            end else begin
                wordValid = 1'b0;
            end
            checkOutput("wordReadyLowWhileBusy", {31'd0, wordReady}, 32'd0);
            if (v.period == 1) checkOutput("noBubble", {31'd0, txValid}, 32'd1);
            if (stalled) checkOutput("holdWhileStalled", {24'd0, txData}, {24'd0, prevData});
            if (txValid && ready) begin
                checkOutput($sformatf("byte%0d", idx), {24'd0, txData}, {24'd0, e[79 - 8*idx -: 8]});
                idx++;
            end
            stalled  = txValid && !ready;
            prevData = txData;
        end
        if (idx < 10) checkOutput("streamTimeout", idx, 10);
    endtask

    initial begin
        vecs[0] = '{32'hDEAD_BEEF, 1, -1, 1'b0, 32'h0, {"DEADBEEF", 8'h0D, 8'h0A}};
        vecs[1] = '{32'hDEAD_BEEF, 4, -1, 1'b0, 32'h0, {"DEADBEEF", 8'h0D, 8'h0A}};
        vecs[2] = '{32'h0000_0000, 1, -1, 1'b1, 32'hFFFF_FFFF, {"00000000", 8'h0D, 8'h0A}};
        vecs[3] = '{32'hFFFF_FFFF, 1, -1, 1'b0, 32'h0, {"FFFFFFFF", 8'h0D, 8'h0A}};
        vecs[4] = '{32'hCAFE_F00D, 2, 3, 1'b0, 32'h0, {"CAFEF00D", 8'h0D, 8'h0A}};
        vecAfterReset = '{32'h0000_000A, 1, -1, 1'b0, 32'h0, {"0000000A", 8'h0D, 8'h0A}};

        reset      = 1'b1;
        wordIn     = '0;
        wordValid  = 1'b0;
        txReady    = 1'b0;
        wordIn8    = '0;
        wordValid8 = 1'b0;
        txReady8   = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("resetTxValid", {31'd0, txValid}, 32'd0);
        checkOutput("resetTxData", {24'd0, txData}, 32'd0);
        checkOutput("resetWordReady", {31'd0, wordReady}, 32'd1);
        checkOutput("resetBusy", {31'd0, busy}, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 5; i++) applyStimulus(vecs[i]);

        // Abort after three digits have been handshaken.
        @(negedge clk);
        checkOutput("idleBeforeAbort", {31'd0, wordReady}, 32'd1);
        wordValid = 1'b1;
        wordIn    = 32'hDEAD_BEEF;
        txReady   = 1'b1;
        @(negedge clk);
        wordValid = 1'b0;
        checkOutput("abortDigit0", {24'd0, txData}, 32'h44);
        @(negedge clk);
        checkOutput("abortDigit1", {24'd0, txData}, 32'h45);
        @(negedge clk);
        checkOutput("abortDigit2", {24'd0, txData}, 32'h41);
        @(negedge clk);
        checkOutput("abortDigit3Pending", {24'd0, txData}, 32'h44);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        txReady = 1'b0;
        checkOutput("abortTxValid", {31'd0, txValid}, 32'd0);
        checkOutput("abortWordReady", {31'd0, wordReady}, 32'd1);
        checkOutput("abortBusy", {31'd0, busy}, 32'd0);
        checkOutput("abortTxData", {24'd0, txData}, 32'd0);

        applyStimulus(vecAfterReset);
        @(negedge clk);
        checkOutput("finalIdleWordReady", {31'd0, wordReady}, 32'd1);
        checkOutput("finalIdleTxValid", {31'd0, txValid}, 32'd0);

        // Narrow instance without line terminator.
        checkOutput("narrowIdle", {31'd0, wordReady8}, 32'd1);
        wordValid8 = 1'b1;
        wordIn8    = 8'h5A;
        txReady8   = 1'b1;
        @(negedge clk);
        wordValid8 = 1'b0;
        checkOutput("narrowValid0", {31'd0, txValid8}, 32'd1);
        checkOutput("narrowByte0", {24'd0, txData8}, 32'h35);
        @(negedge clk);
        checkOutput("narrowValid1", {31'd0, txValid8}, 32'd1);
        checkOutput("narrowByte1", {24'd0, txData8}, 32'h41);
        @(negedge clk);
        checkOutput("narrowDoneValid", {31'd0, txValid8}, 32'd0);
        checkOutput("narrowDoneReady", {31'd0, wordReady8}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
